// File: rtl/axi_wr_chan_router.sv
// AXI4 write slave that routes burst beats into one of NUM_CH input FIFOs by address channel field.
// Optional build macro AXI_WLAST_CHECK_EN: end bursts with SLVERR when wlast disagrees with the beat count.
module axi_wr_chan_router #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned INDEX_W = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_W-1:0]     axs_awid,
  input  logic [ADDR_W-1:0]   axs_awaddr,
  input  logic [7:0]          axs_awlen,
  input  logic [1:0]          axs_awburst,
  input  logic                axs_awvalid,
  output logic                axs_awready,
  input  logic [DATA_W-1:0]   axs_wdata,
  input  logic [DATA_W/8-1:0] axs_wstrb,
  input  logic                axs_wlast,
  input  logic                axs_wvalid,
  output logic                axs_wready,
  output logic [ID_W-1:0]     axs_bid,
  output logic [1:0]          axs_bresp,
  output logic                axs_bvalid,
  input  logic                axs_bready,
  input  logic [NUM_CH-1:0]   ch_full,
  output logic [NUM_CH-1:0]   ch_push,
  output logic [NUM_CH-1:0]   ch_clr,
  output logic [DATA_W-1:0]   ch_data,
  output logic [DATA_W/8-1:0] ch_strb,
  output logic [INDEX_W-1:0]  ch_index,
  output logic                ch_rec_last
);

  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    awid_q;
  logic [SEL_W-1:0]   sel_q;
  logic               rec_q;
  logic               err_q;
  logic [7:0]         beats_q;
  logic [INDEX_W-1:0] index_q;

  logic sel_full_c;
  logic wready_c;
  logic w_hs_c;
  logic last_beat_c;
  logic wlast_bad_c;
  logic burst_end_c;
  logic aw_err_c;
  logic unused_c;

  // Burst type and upper address bits carry no routing information.
  assign unused_c = ^{axs_awburst, axs_awaddr[ADDR_W-1:8], axs_wlast};

  always_comb begin
    sel_full_c = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == SEL_W'(i)) sel_full_c = ch_full[i];
    end
  end

  assign aw_err_c    = ({1'b0, axs_awaddr[7:4]} >= (SEL_W+1)'(NUM_CH)) ||
                       (axs_awaddr[3:1] != 3'b000);
  assign wready_c    = (state_q == ST_W) && (!sel_full_c || err_q);
  assign w_hs_c      = axs_wvalid && wready_c;
  assign last_beat_c = (beats_q == 8'd0);

`ifdef AXI_WLAST_CHECK_EN
  assign wlast_bad_c = w_hs_c && (axs_wlast != last_beat_c);
`else
  assign wlast_bad_c = 1'b0;
`endif

  assign burst_end_c = w_hs_c && (last_beat_c || wlast_bad_c);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_AW;
      ST_AW:   if (axs_awvalid) state_d = ST_W;
      ST_W:    if (burst_end_c) state_d = ST_B;
      ST_B:    if (axs_bready) state_d = ST_AW;
      default: state_d = ST_INIT;
    endcase
  end

  // Output decode; beat data and strobes pass straight through
  always_comb begin
    axs_awready = 1'b0;
    axs_wready  = 1'b0;
    axs_bvalid  = 1'b0;
    axs_bresp   = 2'b00;
    ch_push     = '0;
    ch_clr      = '0;
    ch_rec_last = 1'b0;
    case (state_q)
      ST_INIT: ch_clr = '1;
      ST_AW:   axs_awready = 1'b1;
      ST_W: begin
        axs_wready = wready_c;
        if (w_hs_c && !err_q) begin
          for (int i = 0; i < NUM_CH; i++) begin
            ch_push[i] = (sel_q == SEL_W'(i));
          end
          ch_rec_last = rec_q && last_beat_c && !wlast_bad_c;
        end
      end
      ST_B: begin
        axs_bvalid = 1'b1;
        axs_bresp  = err_q ? 2'b10 : 2'b00;
      end
      default: ch_clr = '1;
    endcase
  end

  assign axs_bid  = awid_q;
  assign ch_data  = axs_wdata;
  assign ch_strb  = axs_wstrb;
  assign ch_index = index_q;

  // Burst context and shared record index
  always_ff @(posedge clk) begin
    if (reset) begin
      awid_q  <= '0;
      sel_q   <= '0;
      rec_q   <= 1'b0;
      err_q   <= 1'b0;
      beats_q <= '0;
      index_q <= '0;
    end else begin
      if (state_q == ST_AW && axs_awvalid) begin
        awid_q  <= axs_awid;
        sel_q   <= axs_awaddr[7:4];
        rec_q   <= axs_awaddr[0];
        err_q   <= aw_err_c;
        beats_q <= axs_awlen;
      end
      if (w_hs_c) begin
        beats_q <= beats_q - 8'd1;
        if (wlast_bad_c) err_q <= 1'b1;
      end
      if (state_q == ST_B && axs_bready && rec_q && !err_q) begin
        index_q <= index_q + INDEX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_chan_router.sv
// Scoreboard bench for axi_wr_chan_router: driver queues expected pushes/responses, negedge monitor checks them.
module tb_axi_wr_chan_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  axs_awid;
  logic [31:0] axs_awaddr;
  logic [7:0]  axs_awlen;
  logic [1:0]  axs_awburst;
  logic        axs_awvalid;
  logic        axs_awready;
  logic [31:0] axs_wdata;
  logic [3:0]  axs_wstrb;
  logic        axs_wlast;
  logic        axs_wvalid;
  logic        axs_wready;
  logic [3:0]  axs_bid;
  logic [1:0]  axs_bresp;
  logic        axs_bvalid;
  logic        axs_bready;
  logic [3:0]  ch_full;
  logic [3:0]  ch_push;
  logic [3:0]  ch_clr;
  logic [31:0] ch_data;
  logic [3:0]  ch_strb;
  logic [9:0]  ch_index;
  logic        ch_rec_last;

  always #5 clk = ~clk;

  axi_wr_chan_router dut (
    .clk(clk), .reset(reset),
    .axs_awid(axs_awid), .axs_awaddr(axs_awaddr), .axs_awlen(axs_awlen),
    .axs_awburst(axs_awburst), .axs_awvalid(axs_awvalid), .axs_awready(axs_awready),
    .axs_wdata(axs_wdata), .axs_wstrb(axs_wstrb), .axs_wlast(axs_wlast),
    .axs_wvalid(axs_wvalid), .axs_wready(axs_wready),
    .axs_bid(axs_bid), .axs_bresp(axs_bresp), .axs_bvalid(axs_bvalid), .axs_bready(axs_bready),
    .ch_full(ch_full), .ch_push(ch_push), .ch_clr(ch_clr), .ch_data(ch_data),
    .ch_strb(ch_strb), .ch_index(ch_index), .ch_rec_last(ch_rec_last)
  );

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        rec_last;
    logic [9:0]  idx;
  } push_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  push_t      pq[$];
  b_t         bq[$];
  int         total = 0;
  int         bad = 0;
  int         push_cnt = 0;
  logic [9:0] exp_idx = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop an expectation whenever the DUT pushes a beat or completes a response
  always @(negedge clk) begin
    push_t      e;
    b_t         r;
    logic [3:0] vec;
    if (!reset) begin
      if (ch_push != 4'b0000) begin
        push_cnt++;
        if (pq.size() == 0) begin
          chk("unexpected_push", 64'(ch_push), 64'(0));
        end else begin
          e = pq.pop_front();
          vec = 4'b0001 << e.ch;
          chk("push_vec", 64'(ch_push), 64'(vec));
          chk("push_data", 64'(ch_data), 64'(e.data));
          chk("push_strb", 64'(ch_strb), 64'(e.strb));
          chk("push_rec_last", 64'(ch_rec_last), 64'(e.rec_last));
          chk("push_index", 64'(ch_index), 64'(e.idx));
        end
      end
      if (axs_bvalid && axs_bready) begin
        if (bq.size() == 0) begin
          chk("unexpected_bresp", 64'(axs_bvalid), 64'(0));
        end else begin
          r = bq.pop_front();
          chk("bid", 64'(axs_bid), 64'(r.id));
          chk("bresp", 64'(axs_bresp), 64'(r.resp));
        end
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int n = 0;
    axs_awid = id; axs_awaddr = addr; axs_awlen = len; axs_awburst = burst; axs_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!axs_awready && n < 100);
    chk("awready_wait", 64'(axs_awready), 64'(1));
    @(posedge clk); #1 axs_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    axs_wdata = d; axs_wstrb = s; axs_wlast = last; axs_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!axs_wready && n < 100);
    chk("wready_wait", 64'(axs_wready), 64'(1));
    @(posedge clk); #1 axs_wvalid = 1'b0;
  endtask

  task automatic get_b(input int delay, input logic [3:0] id, input logic [1:0] resp);
    int n = 0;
    axs_bready = 1'b0;
    do begin @(negedge clk); n++; end while (!axs_bvalid && n < 100);
    chk("bvalid_wait", 64'(axs_bvalid), 64'(1));
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); @(negedge clk);
      chk("bvalid_hold", 64'(axs_bvalid), 64'(1));
      chk("bid_hold", 64'(axs_bid), 64'(id));
      chk("bresp_hold", 64'(axs_bresp), 64'(resp));
    end
    @(posedge clk); #1 axs_bready = 1'b1;
    @(posedge clk); #1 axs_bready = 1'b0;
  endtask

  function automatic logic [3:0] strb_of(input int b);
    return 4'hF >> (b % 4);
  endfunction

  task automatic queue_beats(input logic [31:0] addr, input int nbeats, input int len,
                             input logic [31:0] base);
    push_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.ch = addr[7:4]; e.data = base + 32'(b); e.strb = strb_of(b);
      e.rec_last = addr[0] && (b == len); e.idx = exp_idx;
      pq.push_back(e);
    end
  endtask

  task automatic write(input logic [3:0] id, input logic [31:0] addr, input int len,
                       input logic [31:0] base, input bit err, input int bdelay);
    b_t r;
    if (!err) queue_beats(addr, len + 1, len, base);
    r.id = id; r.resp = err ? 2'b10 : 2'b00;
    bq.push_back(r);
    send_aw(id, addr, 8'(len), 2'b01);
    for (int b = 0; b <= len; b++) send_w(base + 32'(b), strb_of(b), b == len);
    get_b(bdelay, id, r.resp);
    if (addr[0] && !err) exp_idx = exp_idx + 10'd1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b_t r;
    reset = 1'b1;
    axs_awid = '0; axs_awaddr = '0; axs_awlen = '0; axs_awburst = 2'b01; axs_awvalid = 1'b0;
    axs_wdata = '0; axs_wstrb = '0; axs_wlast = 1'b0; axs_wvalid = 1'b0; axs_bready = 1'b0;
    ch_full = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(axs_awready), 64'(0));
    chk("rst_wready", 64'(axs_wready), 64'(0));
    chk("rst_bvalid", 64'(axs_bvalid), 64'(0));
    chk("rst_bresp", 64'(axs_bresp), 64'(0));
    chk("rst_push", 64'(ch_push), 64'(0));
    chk("rst_clr", 64'(ch_clr), 64'hF);
    chk("rst_index", 64'(ch_index), 64'(0));
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("init_clr", 64'(ch_clr), 64'hF);
    chk("init_awready", 64'(axs_awready), 64'(0));
    @(negedge clk);
    chk("aw_clr", 64'(ch_clr), 64'h0);
    chk("aw_awready", 64'(axs_awready), 64'(1));
    @(posedge clk); #1;

    // Single beat to channel 2
    write(4'd3, 32'h20, 0, 32'hDEADBEEF, 1'b0, 0);
    chk("t1_index", 64'(ch_index), 64'(0));

    // Four-beat last-flagged burst to channel 1
    write(4'd5, 32'h11, 3, 32'h1000_0000, 1'b0, 0);
    chk("t2_index", 64'(ch_index), 64'(1));

    // FIXED burst to ch0 with ch0 full while beat 2 waits; ch2 full throughout is ignored
    queue_beats(32'h00, 4, 3, 32'hA000_0000);
    r.id = 4'd9; r.resp = 2'b00; bq.push_back(r);
    ch_full = 4'b0100;
    send_aw(4'd9, 32'h00, 8'd3, 2'b00);
    send_w(32'hA000_0000, strb_of(0), 1'b0);
    axs_wdata = 32'hA000_0001; axs_wstrb = strb_of(1); axs_wlast = 1'b0; axs_wvalid = 1'b1;
    ch_full = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_wready", 64'(axs_wready), 64'(0));
      @(posedge clk); #1;
    end
    ch_full = 4'b0100;
    send_w(32'hA000_0001, strb_of(1), 1'b0);
    send_w(32'hA000_0002, strb_of(2), 1'b0);
    send_w(32'hA000_0003, strb_of(3), 1'b1);
    get_b(0, 4'd9, 2'b00);
    ch_full = 4'b0000;
    chk("t3_pushes", 64'(push_cnt), 64'(9));

    // Bad channel and misaligned address: drained, nothing pushed, SLVERR
    write(4'd7, 32'h50, 1, 32'hBAD0_0000, 1'b1, 0);
    write(4'd2, 32'h23, 0, 32'hBAD1_0000, 1'b1, 0);
    chk("err_pushes", 64'(push_cnt), 64'(9));
    chk("err_index", 64'(ch_index), 64'(1));

    // Address and data offered together: only the address is taken in AW
    queue_beats(32'h30, 1, 0, 32'h5555_0000);
    r.id = 4'd4; r.resp = 2'b00; bq.push_back(r);
    axs_awid = 4'd4; axs_awaddr = 32'h30; axs_awlen = 8'd0; axs_awvalid = 1'b1;
    axs_wdata = 32'h5555_0000; axs_wstrb = strb_of(0); axs_wlast = 1'b1; axs_wvalid = 1'b1;
    @(negedge clk);
    chk("sim_awready", 64'(axs_awready), 64'(1));
    chk("sim_wready", 64'(axs_wready), 64'(0));
    chk("sim_push", 64'(ch_push), 64'(0));
    @(posedge clk); #1 axs_awvalid = 1'b0;
    send_w(32'h5555_0000, strb_of(0), 1'b1);
    get_b(0, 4'd4, 2'b00);

`ifdef AXI_WLAST_CHECK_EN
    // Early wlast on beat 2 of 4: two pushes, SLVERR, index held
    queue_beats(32'h11, 2, 3, 32'h7700_0000);
    pq[pq.size()-1].rec_last = 1'b0;
    r.id = 4'd6; r.resp = 2'b10; bq.push_back(r);
    send_aw(4'd6, 32'h11, 8'd3, 2'b01);
    send_w(32'h7700_0000, strb_of(0), 1'b0);
    send_w(32'h7700_0001, strb_of(1), 1'b1);
    get_b(0, 4'd6, 2'b10);
    chk("wl_pushes", 64'(push_cnt), 64'(12));
    chk("wl_index", 64'(ch_index), 64'(1));
`else
    // wlast disagreeing with the count is ignored: both beats pushed, OKAY
    queue_beats(32'h30, 2, 1, 32'h7700_0000);
    r.id = 4'd6; r.resp = 2'b00; bq.push_back(r);
    send_aw(4'd6, 32'h30, 8'd1, 2'b01);
    send_w(32'h7700_0000, strb_of(0), 1'b1);
    send_w(32'h7700_0001, strb_of(1), 1'b0);
    get_b(0, 4'd6, 2'b00);
    chk("wl_pushes", 64'(push_cnt), 64'(12));
`endif

    // Drive the index up to 1023, then wrap it with a slow-bready response
    while (exp_idx != 10'd1023) write(4'd1, 32'h01, 0, 32'h0000_0100 + 32'(exp_idx), 1'b0, 0);
    chk("idx_1023", 64'(ch_index), 64'd1023);
    write(4'd11, 32'h21, 0, 32'hCAFE_F00D, 1'b0, 5);
    chk("idx_wrap", 64'(ch_index), 64'd0);

    // Reset in the middle of a burst
    exp_idx = 10'd5;
    queue_beats(32'h10, 1, 3, 32'hEE00_0000);
    pq[pq.size()-1].idx = ch_index;
    send_aw(4'd8, 32'h10, 8'd3, 2'b01);
    send_w(32'hEE00_0000, strb_of(0), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_idx = '0;
    @(negedge clk);
    chk("mrst_clr", 64'(ch_clr), 64'hF);
    chk("mrst_awready", 64'(axs_awready), 64'(0));
    chk("mrst_wready", 64'(axs_wready), 64'(0));
    @(negedge clk);
    chk("mrst_clr_off", 64'(ch_clr), 64'h0);
    chk("mrst_awready_on", 64'(axs_awready), 64'(1));
    chk("mrst_index", 64'(ch_index), 64'(0));
    @(posedge clk); #1;

    chk("pq_empty", 64'(pq.size()), 64'(0));
    chk("bq_empty", 64'(bq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_chan_router.md
Name: axi_wr_chan_router

Overview:
- Generalised AXI4 write-slave front end for the accelerator input datapath.
- Accepts single-beat and INCR/FIXED burst writes and decodes a channel number from the address.
- Pushes each accepted data beat, with its strobe and the shared record index, into one of NUM_CH input FIFOs, stalling per channel on FIFO full.
- Sits between the interconnect slave port and the varint and raw-data input FIFO banks; replaces the fixed two-channel single-beat controller.

Parameters:
- DATA_W, 32, width of wdata and ch_data.
- ID_W, 4, AXI ID width.
- ADDR_W, 32, AXI address width.
- NUM_CH, 4, number of input channels (1..16).
- INDEX_W, 10, width of the shared record index (wraps modulo 2^INDEX_W).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- axs_awid  in  ID_W  write address ID
- axs_awaddr  in  ADDR_W  write address; [7:4] = channel, [0] = last-of-record flag
- axs_awlen  in  8  beats minus 1
- axs_awburst  in  2  00 FIXED, 01 INCR; others treated as INCR
- axs_awvalid  in  1  address valid
- axs_awready  out  1  address ready
- axs_wdata  in  DATA_W  write data
- axs_wstrb  in  DATA_W/8  byte strobes
- axs_wlast  in  1  last beat
- axs_wvalid  in  1  data valid
- axs_wready  out  1  data ready
- axs_bid  out  ID_W  response ID (= latched awid)
- axs_bresp  out  2  00 OKAY, 10 SLVERR
- axs_bvalid  out  1  response valid
- axs_bready  in  1  response ready
- ch_full  in  NUM_CH  per-channel FIFO full
- ch_push  out  NUM_CH  one-hot push strobe
- ch_clr  out  NUM_CH  FIFO clear
- ch_data  out  DATA_W  beat data (combinational pass-through of wdata)
- ch_strb  out  DATA_W/8  beat strobes (pass-through)
- ch_index  out  INDEX_W  current record index
- ch_rec_last  out  1  beat is final beat of a last-flagged burst

Behaviour:
- States: INIT, AW, W, B.
- Reset forces INIT; index, latched awid/addr/beat counter/err cleared. All ready/valid outputs 0 and bresp 00 from reset. ch_clr is all-ones only while in INIT; ch_push is 0.
- INIT: lasts one cycle, then AW.
- AW: awready=1. On awvalid:
  - latch awid, channel sel=awaddr[7:4], rec_flag=awaddr[0], beats_left=awlen;
  - err=1 when sel>=NUM_CH or awaddr[3:1]!=0;
  - go to W.
  - Channel full is NOT checked in AW; it is handled per beat in W.
- W: wready = ~ch_full[sel] | err.
  - Handshake (wvalid&wready): if ~err, ch_push[sel]=1 in the same cycle with ch_data/ch_strb = wdata/wstrb (0-cycle latency). beats_left decrements.
  - On the handshake where beats_left==0: ch_rec_last = rec_flag, and go to B.
  - err bursts are fully drained (all beats accepted, nothing pushed).
- B: bvalid=1, bid=latched awid, bresp = err ? 10 : 00. Held stable until bready. On bready: if rec_flag & ~err, index increments (2^INDEX_W-1 wraps to 0); state goes to AW.
- Addresses are not incremented; FIXED and INCR behave identically (every beat goes to the same FIFO).
- ch_full[sel] rising mid-burst: wready drops the same cycle; no beat is lost or duplicated. ch_full of other channels is ignored.
- Simultaneous awvalid and wvalid in AW: only the address is taken; wready stays 0 until W.
- reset mid-burst: state goes to INIT; the partial burst is abandoned; FIFOs are cleared via ch_clr the next cycle.
- Illegal state encoding goes to INIT.

Optional Feature:
- AXI_WLAST_CHECK_EN defined: wlast is compared with (beats_left==0) on every handshake.
  - Early wlast: burst ends, state goes to B, SLVERR.
  - Missing wlast on the counted last beat: burst ends, SLVERR.
  - Beats already pushed stay pushed; index does not increment.
- Undefined: wlast is ignored and beat counting alone ends the burst.

Test Plan:
- Single write addr 0x20, data 0xDEADBEEF, strb F: ch_push=4'b0100 for one cycle with ch_data=0xDEADBEEF; bresp=00, bid=awid; index unchanged.
- addr 0x11, awlen=3, 4 beats: four pushes on ch1; ch_rec_last=1 on beat 4 only; index 0 becomes 1 after bready.
- ch_full[0]=1 during beats 2-3 of a 4-beat burst to 0x00: wready=0 for exactly those cycles; exactly 4 pushes, in order.
- addr 0x50 (NUM_CH=4), awlen=1: both beats accepted, zero pushes, bresp=10.
- Index at 1023 plus a last-flagged write: index becomes 0. bready held low 5 cycles: bvalid/bid/bresp stable, then AW.
- With AXI_WLAST_CHECK_EN: awlen=3 with wlast on beat 2 gives 2 pushes, bresp=10, index unchanged; reset asserted mid-burst gives INIT, ch_clr all-ones for one cycle, awready=1 afterwards.
